// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: per-slot key-on state replayed in slot order. Writes are
// queued and applied on the target channel's S4 slot, with CSM bursts and edge pulses.
module jt12_kon_seq #(
  parameter int num_ch     = 6,
  parameter int fifo_depth = 4,
  parameter int csm_ch     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [3:0] keyon_op,
  input  logic [2:0] keyon_ch,
  input  logic       up_keyon,
  input  logic [1:0] next_op,
  input  logic [2:0] next_ch,
  input  logic       csm,
  input  logic       overflow_A,
  output logic       keyon_I,
  output logic       kon_edge,
  output logic       koff_edge,
  output logic       fifo_full,
  output logic       fifo_ovf
);

  localparam int aw = $clog2(fifo_depth);
  localparam int cw = $clog2(fifo_depth + 1);
  localparam logic [3:0]    nch   = 4'(num_ch);
  localparam logic [cw-1:0] depth = cw'(fifo_depth);

  // Arrays span all 8 encodable channels; entries >= num_ch are never written.
  logic [3:0]    kst  [8];
  logic [3:0]    prev [8];
  logic [6:0]    fifo_mem [fifo_depth];
  logic [aw-1:0] rd_ptr, wr_ptr;
  logic [cw-1:0] count, count_next;
  logic          csm_win, win_next;
  logic [4:0]    win_slot, slot_next;

  logic [6:0] head;
  logic       slot_ok, pop, push_ok, push, drop;
  logic [1:0] sel;
  logic [3:0] kst_mask;
  logic       key, prev_bit;

  always_comb begin
    head     = fifo_mem[rd_ptr];
    slot_ok  = {1'b0, next_ch} < nch;
    pop      = (count != '0) && (head[6:4] == next_ch) && (next_op == 2'd3);
    push_ok  = up_keyon && ({1'b0, keyon_ch} < nch);
    push     = push_ok && ((count != depth) || pop);
    drop     = push_ok && !push;

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + cw'(1);
      2'b01:   count_next = count - cw'(1);
      default: count_next = count;
    endcase

    // next_op order is S1,S3,S2,S4; the mask order is S1,S2,S3,S4
    sel = 2'd0;
    case (next_op)
      2'd0: sel = 2'd0;
      2'd1: sel = 2'd2;
      2'd2: sel = 2'd1;
      2'd3: sel = 2'd3;
      default: sel = 2'd0;
    endcase

    win_next  = csm_win;
    slot_next = win_slot;
    if (overflow_A) begin
      win_next  = 1'b1;
      slot_next = {next_op, next_ch};
    end else if (csm_win && (win_slot == {next_op, next_ch})) begin
      win_next = 1'b0;
    end

    kst_mask = pop ? head[3:0] : kst[next_ch];
    key      = (slot_ok & kst_mask[sel]) |
               (csm & win_next & (next_ch == 3'(csm_ch)));
    prev_bit = slot_ok & prev[next_ch][sel];
  end

  always_ff @(posedge clk) begin
    if (clk_en && push) fifo_mem[wr_ptr] <= {keyon_ch, keyon_op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        kst[i]  <= '0;
        prev[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      csm_win   <= 1'b0;
      win_slot  <= '0;
      keyon_I   <= 1'b0;
      kon_edge  <= 1'b0;
      koff_edge <= 1'b0;
      fifo_full <= 1'b0;
      fifo_ovf  <= 1'b0;
    end else if (clk_en) begin
      if (pop) begin
        kst[head[6:4]] <= head[3:0];
        rd_ptr         <= rd_ptr + aw'(1);
      end
      if (push) wr_ptr <= wr_ptr + aw'(1);
      count     <= count_next;
      fifo_full <= (count_next == depth);
      if (drop) fifo_ovf <= 1'b1;
      csm_win   <= win_next;
      win_slot  <= slot_next;
      keyon_I   <= key;
      kon_edge  <= key & ~prev_bit;
      koff_edge <= ~key & prev_bit;
      if (slot_ok) prev[next_ch][sel] <= key;
    end
  end

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Bench for jt12_kon_seq: directed scenarios plus random traffic, checked each
// cycle against a queue-based model of the key-on rules.
module tb_jt12_kon_seq;
  localparam int NCH = 6, DEPTH = 4, CSMCH = 2, NSLOT = 24;

  logic clk = 0, rst = 1, clk_en = 0, up_keyon = 0, csm = 0, overflow_A = 0;
  logic [3:0] keyon_op = '0;
  logic [2:0] keyon_ch = '0;
  logic [1:0] next_op = '0;
  logic [2:0] next_ch = '0;
  logic keyon_I, kon_edge, koff_edge, fifo_full, fifo_ovf;

  int n_chk = 0, n_pass = 0;
  int pos = 0;

  always #5 clk = ~clk;

  jt12_kon_seq #(.num_ch(NCH), .fifo_depth(DEPTH), .csm_ch(CSMCH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .keyon_op(keyon_op), .keyon_ch(keyon_ch),
    .up_keyon(up_keyon), .next_op(next_op), .next_ch(next_ch), .csm(csm),
    .overflow_A(overflow_A), .keyon_I(keyon_I), .kon_edge(kon_edge),
    .koff_edge(koff_edge), .fifo_full(fifo_full), .fifo_ovf(fifo_ovf)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  // Model: key state per channel as a S1..S4 mask, last output per (ch, next_op)
  logic [3:0] m_kst  [NCH];
  logic [3:0] m_prev [NCH];
  logic [6:0] m_q [$];
  logic m_win = 0, m_ovf = 0;
  int   m_wslot = 0;
  logic e_key = 0, e_on = 0, e_off = 0, e_full = 0, e_ovf = 0;

  function automatic int opbit(input logic [1:0] o);
    if (o == 2'd1) return 2;
    if (o == 2'd2) return 1;
    return int'(o);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NCH; i++) begin m_kst[i] = '0; m_prev[i] = '0; end
    m_q.delete();
    m_win = 0; m_ovf = 0; m_wslot = 0;
    e_key = 0; e_on = 0; e_off = 0; e_full = 0; e_ovf = 0;
  endtask

  task automatic m_step();
    int sl;
    logic p;
    sl = int'(next_op) * 8 + int'(next_ch);
    if (m_q.size() > 0 && m_q[0][6:4] == next_ch && next_op == 2'd3) begin
      m_kst[next_ch] = m_q[0][3:0];
      void'(m_q.pop_front());
    end
    if (up_keyon && int'(keyon_ch) < NCH) begin
      if (m_q.size() < DEPTH) m_q.push_back({keyon_ch, keyon_op});
      else m_ovf = 1;
    end
    if (overflow_A) begin m_win = 1; m_wslot = sl; end
    else if (m_win && m_wslot == sl) m_win = 0;
    e_key = m_kst[next_ch][opbit(next_op)] | (csm && m_win && int'(next_ch) == CSMCH);
    p = m_prev[next_ch][next_op];
    e_on  = e_key & ~p;
    e_off = ~e_key & p;
    m_prev[next_ch][next_op] = e_key;
    e_full = (m_q.size() == DEPTH);
    e_ovf  = m_ovf;
  endtask

  always @(posedge clk) begin
    if (rst) m_clear();
    else if (clk_en) m_step();
    #1;
    chk("keyon_I", keyon_I, e_key);
    chk("kon_edge", kon_edge, e_on);
    chk("koff_edge", koff_edge, e_off);
    chk("fifo_full", fifo_full, e_full);
    chk("fifo_ovf", fifo_ovf, e_ovf);
  end

  task automatic cyc(input logic en = 1, input logic up = 0, input logic [2:0] ch = 0,
                     input logic [3:0] op = 0, input logic ovfa = 0);
    @(negedge clk);
    clk_en = en; up_keyon = up; keyon_ch = ch; keyon_op = op; overflow_A = ovfa;
    next_op = 2'(pos / NCH);
    next_ch = 3'(pos % NCH);
    if (en) pos = (pos + 1) % NSLOT;
  endtask

  // Drive idle slots until slot p has just been driven (at most one rotation)
  task automatic run_to(input int p);
    int last;
    do begin last = pos; cyc(); end while (last != p);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clk_en = 0; up_keyon = 0; overflow_A = 0;
    #1;
    chk("rst_keyon", keyon_I, 1'b0);
    chk("rst_kon", kon_edge, 1'b0);
    chk("rst_koff", koff_edge, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_ovf", fifo_ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    settle();
    chk("init_keyon", keyon_I, 1'b0);
    chk("init_full", fifo_full, 1'b0);
    chk("init_ovf", fifo_ovf, 1'b0);

    // ch1 all operators on: S4 first, then S1 on the next rotation
    cyc(1, 1, 3'd1, 4'hF);
    run_to(19); settle();
    chk("t1_s4_key", keyon_I, 1'b1);
    chk("t1_s4_kon", kon_edge, 1'b1);
    run_to(20); settle();
    chk("t1_ch2_key", keyon_I, 1'b0);
    run_to(1); settle();
    chk("t1_s1_key", keyon_I, 1'b1);
    chk("t1_s1_kon", kon_edge, 1'b1);
    run_to(19); settle();
    chk("t1_s4_again_kon", kon_edge, 1'b0);

    // back-to-back ch0 on/off
    cyc(1, 1, 3'd0, 4'hF);
    cyc(1, 1, 3'd0, 4'h0);
    run_to(18); settle();
    chk("t2_on_key", keyon_I, 1'b1);
    run_to(18); settle();
    chk("t2_off_key", keyon_I, 1'b0);
    chk("t2_off_koff", koff_edge, 1'b1);
    repeat (30) cyc();

    // FIFO fill, push during pop while full, then a dropped write
    do_reset();
    run_to(0);
    cyc(1, 1, 3'd5, 4'h1);
    cyc(1, 1, 3'd5, 4'h2);
    cyc(1, 1, 3'd5, 4'h4);
    cyc(1, 1, 3'd5, 4'h8);
    settle();
    chk("t3_full", fifo_full, 1'b1);
    chk("t3_noovf", fifo_ovf, 1'b0);
    run_to(22);
    cyc(1, 1, 3'd5, 4'hF);
    settle();
    chk("t3_popush_full", fifo_full, 1'b1);
    chk("t3_popush_noovf", fifo_ovf, 1'b0);
    cyc(1, 1, 3'd5, 4'h3);
    settle();
    chk("t3_drop_ovf", fifo_ovf, 1'b1);
    repeat (120) cyc();

    // CSM window on ch2, restarted mid-window
    do_reset();
    csm = 1;
    run_to(3);
    cyc(1, 0, 3'd0, 4'h0, 1'b1);
    run_to(8); settle();
    chk("t4_csm_key", keyon_I, 1'b1);
    run_to(15);
    cyc(1, 0, 3'd0, 4'h0, 1'b1);
    run_to(20); settle();
    chk("t4_ext_key", keyon_I, 1'b1);
    run_to(20); settle();
    chk("t4_end_key", keyon_I, 1'b0);
    chk("t4_end_koff", koff_edge, 1'b1);
    csm = 0;
    repeat (30) cyc();

    // out-of-range channel is ignored without a flag
    cyc(1, 1, 3'd7, 4'hF);
    settle();
    chk("t5_full", fifo_full, 1'b0);
    chk("t5_ovf", fifo_ovf, 1'b0);
    repeat (30) cyc();

    // reset with three writes pending while a key is on
    cyc(1, 1, 3'd3, 4'hF);
    run_to(21);
    run_to(12);
    cyc(1, 1, 3'd5, 4'h1);
    cyc(1, 1, 3'd5, 4'h2);
    cyc(1, 1, 3'd5, 4'h4);
    settle();
    chk("t6_pre_key", keyon_I, 1'b1);
    do_reset();
    repeat (50) cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) csm = 1'($urandom_range(0, 1));
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0, 3'($urandom),
          4'($urandom), $urandom_range(0, 40) == 0);
    end
    repeat (2) cyc();

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jt12_kon_seq.md
# jt12_kon_seq

Parametrised key-on sequencer for the FM operator pipeline. It holds the key-on state of every operator slot and replays it in slot order as `keyon_I` for the envelope generator. Key-on register writes are queued in a small FIFO, so back-to-back writes are not lost. It also generates CSM (timer A) key-on bursts on a selectable channel, and per-slot key-on/key-off edge pulses.

## Interface
Parameters:
- `num_ch`, 6, channel count, 1..8; slots = 4*`num_ch`
- `fifo_depth`, 4, pending key-on write entries, power of two, 2..16
- `csm_ch`, 2, channel that receives CSM key-on

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `clk_en` in 1: clock enable; all state advances only when it is high
- `keyon_op` in 4: operator mask, bit0=S1, bit1=S2, bit2=S3, bit3=S4
- `keyon_ch` in 3: target channel of a write
- `up_keyon` in 1: one-cycle write strobe
- `next_op` in 2: slot operator; 0=S1, 1=S3, 2=S2, 3=S4
- `next_ch` in 3: slot channel, 0..`num_ch`-1
- `csm` in 1: CSM mode enable
- `overflow_A` in 1: timer A overflow pulse
- `keyon_I` out 1: key-on for the slot presented on the previous enabled cycle
- `kon_edge` out 1: that slot went from key-off to key-on since its last visit
- `koff_edge` out 1: that slot went from key-on to key-off since its last visit
- `fifo_full` out 1: FIFO holds `fifo_depth` entries
- `fifo_ovf` out 1: sticky; a write was dropped

## Operation
- **State storage:** `kst[ch][op]`, 4*`num_ch` bits, plus `prev[ch][op]` holding the last emitted `keyon_I` of each slot.
- **Write push:** on `up_keyon`, push {`keyon_ch`, `keyon_op`}.
  - If `keyon_ch` >= `num_ch`: write ignored; no push, no flag.
  - If FIFO full: write dropped and `fifo_ovf` set.
- **Write apply:**
  - Pop condition: FIFO not empty, head.ch == `next_ch`, and `next_op` == 3 (the channel's S4 slot).
  - On pop, all four `kst[head.ch]` bits are loaded from head.op.
  - Only one entry is applied per slot. A second entry for the same channel waits for that channel's next S4 slot, 4*`num_ch` enabled cycles later.
  - An entry for a different channel blocks the queue until its own S4 slot arrives (strict FIFO order).
- **Simultaneous push and pop:** both occur and the count is unchanged. Push-when-full with a simultaneous pop is accepted, not dropped.
- **CSM window:**
  - `overflow_A` sets `csm_win` and records {`next_op`, `next_ch`} as the window slot.
  - `csm_win` clears when the same slot recurs without `overflow_A`, i.e. the window lasts one full rotation.
  - `overflow_A` during an open window restarts the window at the new slot.
  - While `csm` and `csm_win` are high, every slot with `next_ch` == `csm_ch` is keyed on. `kst` is not modified.
- **Output:** `keyon_I` = `kst'` | (`csm` & `csm_win'` & `next_ch`==`csm_ch`).
  - `kst'` is the post-apply value, so the applying S4 slot already shows the new bit.
  - `csm_win'` includes a set from `overflow_A` in the same cycle.
- **Edges:** `kon_edge` = `keyon_I` & ~`prev`; `koff_edge` = ~`keyon_I` & `prev`. `prev` for the slot is then updated to `keyon_I`.
- **Reset:**
  - `rst` asynchronously clears `kst`, `prev`, FIFO pointers and count, `csm_win`, `fifo_ovf`, and all outputs to 0.
  - Reset mid-operation discards all pending writes.
  - The first visit after reset produces no `koff_edge`.

## Timing
- All registers update on `clk` rising edges with `clk_en`=1; with `clk_en`=0 every output holds.
- Latency: the slot presented at enabled cycle n appears on `keyon_I`, `kon_edge` and `koff_edge` after enabled edge n.
- A pushed entry is visible from the next enabled cycle. A push coinciding with its own S4 slot applies on the next rotation.
- Worst-case write-to-key latency: `fifo_depth`*4*`num_ch` enabled cycles.
- `fifo_full` and `fifo_ovf` are registered and valid one enabled cycle after the causing push or pop.

## Test plan
- Reset, 6 ch, write ch1 mask 4'b1111 -> `keyon_I`=1 from ch1 S4 slot onward, then on S1, S3 and S2 of ch1 on their next visits, each with exactly one `kon_edge`. All other slots stay 0.
- Writes ch0=1111 then ch0=0000 in consecutive cycles -> keys on for one rotation (24 slots), then a `koff_edge` on each ch0 slot. No write lost.
- Five writes into a depth-4 FIFO, with no matching slot reached in between -> `fifo_full`=1, `fifo_ovf`=1, fifth write never applied. Pushing at a pop cycle while full -> no overflow.
- `csm`=1, `overflow_A` pulse at slot {0,4} -> all four ch2 slots keyed on for exactly 24 enabled cycles. `kst` for ch2 is unchanged afterwards. A second pulse mid-window extends the window.
- Write ch7 with `num_ch`=6 -> ignored, no flag. `num_ch`=3 with a write to ch2 works and the rotation is 12 slots.
- Assert `rst` mid-rotation with 3 entries pending -> all outputs 0 immediately. The FIFO is empty after release, and no `koff_edge` appears on the first rotation.
